// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths, fetch FSM encoding and PC step.
package cpu_pkg;

  localparam int CPU_ADDR_WIDTH = 16;
  localparam int CPU_DATA_WIDTH = 16;
  localparam int PC_INC         = 2;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: one-entry output register toward decode, redirect
// handling and a sticky fault state for out-of-range instruction memory accesses.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int          ADDR_WIDTH = CPU_ADDR_WIDTH,
  parameter int          DATA_WIDTH = CPU_DATA_WIDTH,
  parameter int unsigned RESET_PC   = 32'd0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_address,
  input  logic [DATA_WIDTH-1:0] imem_data,
  input  logic                  imem_unvalid,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  fetch_fault,
  output logic [ADDR_WIDTH-1:0] fault_pc,
  output logic [15:0]           fetch_count
);

  localparam logic [ADDR_WIDTH-1:0] RESET_PC_FULL = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] RESET_PC_ALIGNED = {RESET_PC_FULL[ADDR_WIDTH-1:1], 1'b0};

  fetch_state_e          state_r, state_next_s;
  logic [ADDR_WIDTH-1:0] pc_r, pc_next_s;
  logic                  instr_valid_r, instr_valid_next_s;
  logic [DATA_WIDTH-1:0] instr_r, instr_next_s;
  logic [ADDR_WIDTH-1:0] instr_pc_r, instr_pc_next_s;
  logic [ADDR_WIDTH-1:0] fault_pc_r, fault_pc_next_s;
  logic [15:0]           fetch_count_r, fetch_count_next_s;

  logic slot_free_s;
  logic accept_s;
  logic fetch_s;
  logic fault_s;

  // A redirect masks both fetch and fault decisions for this cycle.
  assign slot_free_s = !instr_valid_r || instr_ready;
  assign accept_s    = instr_valid_r && instr_ready;
  assign fetch_s     = (state_r == ST_RUN) && slot_free_s && !imem_unvalid && !redirect_valid;
  assign fault_s     = (state_r == ST_RUN) && slot_free_s &&  imem_unvalid && !redirect_valid;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state decode; redirect returns to RUN from either state
  always_comb begin
    state_next_s = state_r;
    if (redirect_valid) begin
      state_next_s = ST_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (fault_s) begin
            state_next_s = ST_FAULT;
          end else begin
            state_next_s = ST_RUN;
          end
        end
        ST_FAULT: state_next_s = ST_FAULT;
        default:  state_next_s = ST_RUN;
      endcase
    end
  end

  // Next values of the datapath registers presented to decode
  always_comb begin
    pc_next_s          = pc_r;
    instr_valid_next_s = instr_valid_r;
    instr_next_s       = instr_r;
    instr_pc_next_s    = instr_pc_r;
    fault_pc_next_s    = fault_pc_r;
    fetch_count_next_s = accept_s ? (fetch_count_r + 16'd1) : fetch_count_r;
    if (redirect_valid) begin
      pc_next_s          = {redirect_pc[ADDR_WIDTH-1:1], 1'b0};
      instr_valid_next_s = 1'b0;
    end else if (fetch_s) begin
      instr_next_s       = imem_data;
      instr_pc_next_s    = pc_r;
      instr_valid_next_s = 1'b1;
      pc_next_s          = pc_r + ADDR_WIDTH'(PC_INC);
    end else if (fault_s) begin
      fault_pc_next_s    = pc_r;
      instr_valid_next_s = 1'b0;
    end else if (accept_s) begin
      instr_valid_next_s = 1'b0;
    end else begin
      instr_valid_next_s = instr_valid_r;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r          <= RESET_PC_ALIGNED;
      instr_valid_r <= 1'b0;
      instr_r       <= '0;
      instr_pc_r    <= '0;
      fault_pc_r    <= '0;
      fetch_count_r <= 16'd0;
    end else begin
      pc_r          <= pc_next_s;
      instr_valid_r <= instr_valid_next_s;
      instr_r       <= instr_next_s;
      instr_pc_r    <= instr_pc_next_s;
      fault_pc_r    <= fault_pc_next_s;
      fetch_count_r <= fetch_count_next_s;
    end
  end

  assign imem_address = pc_r;
  assign instr_valid  = instr_valid_r;
  assign instr        = instr_r;
  assign instr_pc     = instr_pc_r;
  assign fetch_fault  = (state_r == ST_FAULT);
  assign fault_pc     = fault_pc_r;
  assign fetch_count  = fetch_count_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch with a behavioural instruction memory
// (1024 words) and a transaction-level reference model of the fetch rules.
module tb_instruction_fetch;

  localparam int MEM_DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] imem_address;
  logic [15:0] imem_data;
  logic        imem_unvalid;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        fetch_fault;
  logic [15:0] fault_pc;
  logic [15:0] fetch_count;

  logic [15:0] mem [0:MEM_DEPTH-1];
  logic        all_valid = 1'b0;

  int total = 0;
  int bad = 0;

  // reference model state
  logic [15:0] m_pc;
  logic        m_valid;
  logic [15:0] m_instr;
  logic [15:0] m_ipc;
  logic        m_fault;
  logic [15:0] m_fpc;
  logic [15:0] m_count;

  instruction_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_address  (imem_address),
    .imem_data     (imem_data),
    .imem_unvalid  (imem_unvalid),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .fetch_fault   (fetch_fault),
    .fault_pc      (fault_pc),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  // instruction memory: word index = address >> 1, out of range beyond MEM_DEPTH words
  always_comb begin
    imem_unvalid = !all_valid && ((imem_address >> 1) >= 16'd1024);
    imem_data    = imem_unvalid ? 16'h0000 : mem[imem_address[10:1]];
  end

  function automatic logic mem_bad(input logic [15:0] a);
    return !all_valid && ((a >> 1) >= 16'd1024);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_valid = 1'b0; m_instr = 16'h0000; m_ipc = 16'h0000;
    m_fault = 1'b0; m_fpc = 16'h0000; m_count = 16'h0000;
  endtask

  // what the next rising edge must do, given the current inputs
  task automatic model_edge();
    if (m_valid && instr_ready) m_count = m_count + 16'd1;
    if (redirect_valid) begin
      m_pc = redirect_pc & 16'hFFFE;
      m_valid = 1'b0;
      m_fault = 1'b0;
    end else if (!m_fault && (!m_valid || instr_ready)) begin
      if (mem_bad(m_pc)) begin
        m_fault = 1'b1;
        m_fpc = m_pc;
        m_valid = 1'b0;
      end else begin
        m_instr = mem[m_pc[10:1]];
        m_ipc = m_pc;
        m_valid = 1'b1;
        m_pc = m_pc + 16'd2;
      end
    end else if (m_valid && instr_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".imem_address"}, 32'(imem_address), 32'(m_pc));
    chk({tag, ".instr_valid"}, 32'(instr_valid), 32'(m_valid));
    if (m_valid) begin
      chk({tag, ".instr"}, 32'(instr), 32'(m_instr));
      chk({tag, ".instr_pc"}, 32'(instr_pc), 32'(m_ipc));
    end
    chk({tag, ".fetch_fault"}, 32'(fetch_fault), 32'(m_fault));
    if (m_fault) chk({tag, ".fault_pc"}, 32'(fault_pc), 32'(m_fpc));
    chk({tag, ".fetch_count"}, 32'(fetch_count), 32'(m_count));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".imem_address"}, 32'(imem_address), 32'h0);
    chk({tag, ".instr_valid"}, 32'(instr_valid), 32'h0);
    chk({tag, ".instr"}, 32'(instr), 32'h0);
    chk({tag, ".instr_pc"}, 32'(instr_pc), 32'h0);
    chk({tag, ".fetch_fault"}, 32'(fetch_fault), 32'h0);
    chk({tag, ".fault_pc"}, 32'(fault_pc), 32'h0);
    chk({tag, ".fetch_count"}, 32'(fetch_count), 32'h0);
  endtask

  task automatic step(input logic rdy, input logic rv, input logic [15:0] rp, input string tag);
    instr_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rp;
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    #2;
    model_reset();
    check_reset_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h300A;
    mem[1] = 16'h3114;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // two words back to back, decode always ready
    step(1'b1, 1'b0, 16'h0, "b2b1");
    chk("b2b1.instr", 32'(instr), 32'h300A);
    chk("b2b1.instr_pc", 32'(instr_pc), 32'h0000);
    step(1'b1, 1'b0, 16'h0, "b2b2");
    chk("b2b2.instr", 32'(instr), 32'h3114);
    chk("b2b2.instr_pc", 32'(instr_pc), 32'h0002);
    step(1'b1, 1'b0, 16'h0, "b2b3");
    chk("b2b3.fetch_count", 32'(fetch_count), 32'd2);

    // decode stall for three cycles after the first word
    do_reset("reset2");
    step(1'b1, 1'b0, 16'h0, "stall0");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 16'h0, "stall");
      chk("stall.instr", 32'(instr), 32'h300A);
      chk("stall.instr_pc", 32'(instr_pc), 32'h0000);
      chk("stall.imem_address", 32'(imem_address), 32'h0002);
    end
    step(1'b1, 1'b0, 16'h0, "unstall");
    chk("unstall.instr", 32'(instr), 32'h3114);
    chk("unstall.instr_pc", 32'(instr_pc), 32'h0002);

    // redirect to an odd target while a word is held
    step(1'b0, 1'b0, 16'h0, "hold");
    step(1'b0, 1'b1, 16'h0007, "redir");
    chk("redir.instr_valid", 32'(instr_valid), 32'h0);
    chk("redir.imem_address", 32'(imem_address), 32'h0006);
    step(1'b1, 1'b0, 16'h0, "redir_next");
    chk("redir_next.instr_pc", 32'(instr_pc), 32'h0006);

    // randomized traffic, redirect targets partly beyond the memory
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
           16'($urandom_range(0, 16'h0900)), "rand");
    end

    // run off the end of the memory, then recover with a redirect
    step(1'b1, 1'b1, 16'h07F0, "edge_redir");
    for (int i = 0; i < 20 && !fetch_fault; i++) step(1'b1, 1'b0, 16'h0, "edge_run");
    chk("oob.fetch_fault", 32'(fetch_fault), 32'h1);
    chk("oob.fault_pc", 32'(fault_pc), 32'h0800);
    chk("oob.instr_valid", 32'(instr_valid), 32'h0);
    step(1'b1, 1'b0, 16'h0, "fault_hold1");
    step(1'b1, 1'b0, 16'h0, "fault_hold2");
    chk("fault_hold.instr_valid", 32'(instr_valid), 32'h0);
    step(1'b1, 1'b1, 16'h0000, "recover");
    chk("recover.fetch_fault", 32'(fetch_fault), 32'h0);
    step(1'b1, 1'b0, 16'h0, "recover_fetch");
    chk("recover_fetch.instr_pc", 32'(instr_pc), 32'h0000);
    chk("recover_fetch.instr", 32'(instr), 32'h300A);

    // pc wraps at the top of the address space
    all_valid = 1'b1;
    step(1'b1, 1'b1, 16'hFFFC, "wrap_redir");
    step(1'b1, 1'b0, 16'h0, "wrap1");
    step(1'b1, 1'b0, 16'h0, "wrap2");
    chk("wrap.instr_pc", 32'(instr_pc), 32'hFFFE);
    chk("wrap.imem_address", 32'(imem_address), 32'h0000);
    step(1'b1, 1'b0, 16'h0, "wrap3");
    all_valid = 1'b0;

    // asynchronous reset in the middle of FAULT
    step(1'b1, 1'b1, 16'h0800, "f2_redir");
    step(1'b1, 1'b0, 16'h0, "f2_fault");
    chk("f2.fetch_fault", 32'(fetch_fault), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 16'h0, "post_rst");
    chk("post_rst.instr_pc", 32'(instr_pc), 32'h0000);
    chk("post_rst.instr", 32'(instr), 32'h300A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, sets the byte-address width.
REQ-002 Parameter DATA_WIDTH, default 16, sets the instruction word width.
REQ-003 Parameter RESET_PC, default 0, is the byte address of the first fetch.
REQ-004 Port clk, input, 1, is the single clock; all state is updated on the rising edge.
REQ-005 Port rst_n, input, 1, is the reset: asynchronous, active-low.
REQ-006 Port imem_address, output, ADDR_WIDTH, is the byte address presented to instruction memory (word index = address>>1).
REQ-007 Port imem_data, input, DATA_WIDTH, is the combinational instruction word returned for imem_address.
REQ-008 Port imem_unvalid, input, 1, is the memory's out-of-range flag for the current imem_address.
REQ-009 Port redirect_valid, input, 1, is a one-cycle branch/jump request.
REQ-010 Port redirect_pc, input, ADDR_WIDTH, is the redirect target.
REQ-011 Port instr_valid, output, 1, means instr and instr_pc hold a fetched word.
REQ-012 Port instr_ready, input, 1, means decode accepts the word this cycle.
REQ-013 Port instr, output, DATA_WIDTH, is the fetched instruction.
REQ-014 Port instr_pc, output, ADDR_WIDTH, is the byte address of instr.
REQ-015 Port fetch_fault, output, 1, is high while the unit is in FAULT.
REQ-016 Port fault_pc, output, ADDR_WIDTH, is the address that caused the fault.
REQ-017 Port fetch_count, output, 16, counts words handed to decode (valid && ready), wrapping at 0xFFFF->0.

Function
REQ-018 The unit SHALL drive imem_address = pc combinationally; pc bit 0 SHALL always be 0.
REQ-019 The FSM SHALL have exactly two states: RUN and FAULT.
REQ-020 Define slot_free = !instr_valid || instr_ready.
REQ-021 In RUN with slot_free and !imem_unvalid, the unit SHALL load instr<=imem_data, instr_pc<=pc, instr_valid<=1, and pc<=pc+2 on the same edge; fetch-to-valid latency is 1 cycle.
REQ-022 In RUN with !slot_free, pc, instr, and instr_pc SHALL hold; instr SHALL stay stable while instr_valid && !instr_ready.
REQ-023 In RUN with slot_free and imem_unvalid, the unit SHALL enter FAULT, set fault_pc<=pc, clear instr_valid, and hold pc.
REQ-024 In FAULT, no fetch SHALL occur; instr_valid SHALL be 0 and fetch_fault 1 until a redirect.
REQ-025 redirect_valid SHALL take priority over all other events, in any state: pc<=redirect_pc with bit 0 cleared, instr_valid<=0 (flush, even if instr_ready is high that cycle), state<=RUN, fetch_fault<=0.
REQ-026 A word accepted (valid && ready) in the same cycle as a redirect SHALL still increment fetch_count.
REQ-027 pc increment SHALL wrap modulo 2^ADDR_WIDTH (0xFFFE -> 0x0000 at default width).
REQ-028 Sustained instr_ready=1 SHALL yield one instruction per cycle.

Reset
REQ-029 While rst_n=0: pc=RESET_PC, state=RUN, instr_valid=0, instr=0, instr_pc=0, fetch_fault=0, fault_pc=0, fetch_count=0.
REQ-030 Reset asserted mid-stall or mid-FAULT SHALL discard all state immediately; the first fetch SHALL occur on the first rising edge after rst_n deasserts.

Structure
REQ-031 ADDR_WIDTH/DATA_WIDTH defaults, the FSM state encoding (RUN=0, FAULT=1), and the PC increment constant 2 SHALL live in a shared package, cpu_pkg.
REQ-032 The block SHALL instantiate no sub-modules; the testbench SHALL pair it with instruction_memory.

Verification
REQ-033 Reset, RESET_PC=0, ready=1, memory words 0x300A, 0x3114 -> instr 0x300A/pc 0x0000 on cycle 1, then 0x3114/pc 0x0002 on cycle 2; fetch_count=2.
REQ-034 ready=0 for 3 cycles after the first valid -> instr, instr_pc, and imem_address stay 0x300A/0x0000/0x0002; on ready=1, the next word follows one cycle later.
REQ-035 Redirect to 0x0007 while a word is valid and not accepted -> instr_valid=0 next cycle, imem_address=0x0006, and the next instr_pc=0x0006.
REQ-036 Fetch reaches byte 0x0800 (MEM_DEPTH=1024 exceeded) -> fetch_fault=1, fault_pc=0x0800, instr_valid=0; a redirect to 0x0000 -> fault clears and the fetch of 0x0000 resumes.
REQ-037 ADDR_WIDTH=16, pc=0xFFFE with an all-valid memory model -> next imem_address=0x0000.
REQ-038 rst_n pulsed low asynchronously between edges during FAULT -> all outputs reach their reset values before the next edge.
